// File: rtl/neurotransmitter_controller_pkg.sv
// Shared constants for the neurotransmitter controller: level field offsets,
// input bit positions and the delta term helper.
package neurotransmitter_controller_pkg;

  localparam int ACC_W_DEF    = 6;
  localparam int BASELINE_DEF = 16;
  localparam int LVL_W        = 2;

  localparam int CORT_LSB = 0;
  localparam int DOP_LSB  = 2;
  localparam int GABA_LSB = 4;
  localparam int NE_LSB   = 6;
  localparam int SER_LSB  = 8;

  localparam int EMO_HAPPY     = 0;
  localparam int EMO_EXCITED   = 1;
  localparam int EMO_STRESSED  = 2;
  localparam int EMO_NERVOUS   = 3;
  localparam int EMO_BORED     = 4;
  localparam int EMO_ANGRY     = 5;
  localparam int EMO_CALM      = 6;
  localparam int EMO_APATHETIC = 7;

  localparam int STIM_HUNGRY   = 11;
  localparam int STIM_STARVING = 12;
  localparam int STIM_TIRED    = 13;

  localparam int ACT_ASLEEP = 0;

  typedef logic signed [5:0] delta_t;

  function automatic delta_t term(input logic en, input delta_t weight);
    return en ? weight : '0;
  endfunction

endpackage

// File: rtl/neurotransmitter_controller_if.sv
// Update strobe, behaviour inputs and level outputs of the controller.
interface neurotransmitter_controller_if;

  logic        tick;
  logic [7:0]  action;
  logic [15:0] stimuli;
  logic [7:0]  emotional_state;
  logic [9:0]  neurotransmitter_level;
  logic        update_done;

  modport master (
    output tick, action, stimuli, emotional_state,
    input  neurotransmitter_level, update_done
  );

  modport slave (
    input  tick, action, stimuli, emotional_state,
    output neurotransmitter_level, update_done
  );

endinterface

// File: rtl/neurotransmitter_controller_nt_accumulator.sv
// One saturating accumulator: applies a signed delta on tick, or decays one
// step toward BASELINE when the delta is zero.
module nt_accumulator #(
  parameter int ACC_W    = 6,
  parameter int BASELINE = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tick,
  input  logic signed [5:0] delta,
  output logic [1:0]        level
);

  localparam int              SUM_W   = ACC_W + 2;
  localparam logic [ACC_W-1:0] ACC_MAX = '1;
  localparam logic [ACC_W-1:0] BASE    = ACC_W'(BASELINE);

  logic [ACC_W-1:0]        acc_q, acc_d;
  logic signed [SUM_W-1:0] sum;

  // Sum is kept two bits wider so both overflow and underflow are visible to the clamp.
  always_comb begin
    sum   = $signed({2'b00, acc_q}) + SUM_W'(delta);
    acc_d = acc_q;
    if (tick) begin
      if (delta != '0) begin
        if (sum < 0)
          acc_d = '0;
        else if (sum > $signed({2'b00, ACC_MAX}))
          acc_d = ACC_MAX;
        else
          acc_d = sum[ACC_W-1:0];
      end else if (acc_q < BASE) begin
        acc_d = acc_q + ACC_W'(1);
      end else if (acc_q > BASE) begin
        acc_d = acc_q - ACC_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) acc_q <= BASE;
    else     acc_q <= acc_d;
  end

  assign level = acc_q[ACC_W-1:ACC_W-2];

endmodule

// File: rtl/neurotransmitter_controller.sv
// Maps behaviour inputs to per-neurotransmitter deltas and drives five
// saturating accumulators; levels are the top two bits of each.
module neurotransmitter_controller
  import neurotransmitter_controller_pkg::*;
#(
  parameter int ACC_W    = ACC_W_DEF,
  parameter int BASELINE = BASELINE_DEF
) (
  input logic                          clk,
  input logic                          rst,
  neurotransmitter_controller_if.slave nt
);

  logic       asleep, hungry, starving, tired;
  logic [7:0] emo;
  delta_t     d_cort, d_dop, d_gaba, d_ne, d_ser;
  logic [9:0] lvl;
  logic       update_done_q, update_done_d;
  logic       unused_bits;

  // Emotions are masked while asleep; the asleep terms themselves still apply.
  always_comb begin
    asleep   = nt.action[ACT_ASLEEP];
    hungry   = nt.stimuli[STIM_HUNGRY];
    starving = nt.stimuli[STIM_STARVING];
    tired    = nt.stimuli[STIM_TIRED];
    emo      = asleep ? 8'h00 : nt.emotional_state;

    d_cort = term(hungry, 6'sd2) + term(starving, 6'sd4)
           + term(emo[EMO_STRESSED], 6'sd1) + term(asleep, -6'sd2);
    d_dop  = term(emo[EMO_HAPPY], 6'sd2) + term(emo[EMO_EXCITED], 6'sd1)
           + term(emo[EMO_BORED], -6'sd2) + term(emo[EMO_APATHETIC], -6'sd1);
    d_gaba = term(asleep, 6'sd2) + term(emo[EMO_CALM], 6'sd1)
           + term(emo[EMO_NERVOUS], -6'sd2) + term(emo[EMO_STRESSED], -6'sd1);
    d_ne   = term(emo[EMO_ANGRY], 6'sd2) + term(emo[EMO_EXCITED], 6'sd1)
           + term(emo[EMO_NERVOUS], 6'sd2) + term(asleep, -6'sd3)
           + term(tired, -6'sd1);
    d_ser  = term(emo[EMO_HAPPY], 6'sd2) + term(emo[EMO_CALM], 6'sd1)
           + term(starving, -6'sd2) + term(tired, -6'sd1)
           + term(emo[EMO_APATHETIC], -6'sd2);

    update_done_d = nt.tick;
  end

  nt_accumulator #(.ACC_W(ACC_W), .BASELINE(BASELINE)) u_cort (
    .clk(clk), .rst(rst), .tick(nt.tick), .delta(d_cort), .level(lvl[CORT_LSB +: LVL_W])
  );
  nt_accumulator #(.ACC_W(ACC_W), .BASELINE(BASELINE)) u_dop (
    .clk(clk), .rst(rst), .tick(nt.tick), .delta(d_dop), .level(lvl[DOP_LSB +: LVL_W])
  );
  nt_accumulator #(.ACC_W(ACC_W), .BASELINE(BASELINE)) u_gaba (
    .clk(clk), .rst(rst), .tick(nt.tick), .delta(d_gaba), .level(lvl[GABA_LSB +: LVL_W])
  );
  nt_accumulator #(.ACC_W(ACC_W), .BASELINE(BASELINE)) u_ne (
    .clk(clk), .rst(rst), .tick(nt.tick), .delta(d_ne), .level(lvl[NE_LSB +: LVL_W])
  );
  nt_accumulator #(.ACC_W(ACC_W), .BASELINE(BASELINE)) u_ser (
    .clk(clk), .rst(rst), .tick(nt.tick), .delta(d_ser), .level(lvl[SER_LSB +: LVL_W])
  );

  always_ff @(posedge clk) begin
    if (rst) update_done_q <= 1'b0;
    else     update_done_q <= update_done_d;
  end

  assign nt.neurotransmitter_level = lvl;
  assign nt.update_done            = update_done_q;

  assign unused_bits = ^{nt.action[7:1], nt.stimuli[10:0], nt.stimuli[15:14]};

endmodule

// File: tb/tb_neurotransmitter_controller.sv
// Randomized and directed checks of neurotransmitter_controller against an
// integer reference model of the accumulator rules.
module tb_neurotransmitter_controller;

  localparam int ACC_W    = 6;
  localparam int BASELINE = 16;
  localparam int MAXV     = (1 << ACC_W) - 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  neurotransmitter_controller_if nt_if();

  neurotransmitter_controller #(.ACC_W(ACC_W), .BASELINE(BASELINE)) dut (
    .clk(clk),
    .rst(rst),
    .nt (nt_if.slave)
  );

  int checks = 0;
  int errors = 0;

  // Model state, index order: CORT, DOP, GABA, NE, SER.
  int   acc [5];
  logic exp_done;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [9:0] exp_level();
    logic [9:0] l;
    for (int i = 0; i < 5; i++) l[2*i +: 2] = 2'(acc[i] >> (ACC_W - 2));
    return l;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 5; i++) acc[i] = BASELINE;
  endtask

  task automatic model_tick(input logic [7:0] a, input logic [15:0] s, input logic [7:0] e);
    int d [5];
    int sl, hu, st, ti;
    int ha, ex, sr, nv, bo, an, ca, ap;
    int v;
    sl = int'(a[0]);
    hu = int'(s[11]); st = int'(s[12]); ti = int'(s[13]);
    ha = sl ? 0 : int'(e[0]); ex = sl ? 0 : int'(e[1]);
    sr = sl ? 0 : int'(e[2]); nv = sl ? 0 : int'(e[3]);
    bo = sl ? 0 : int'(e[4]); an = sl ? 0 : int'(e[5]);
    ca = sl ? 0 : int'(e[6]); ap = sl ? 0 : int'(e[7]);
    d[0] = 2*hu + 4*st + sr - 2*sl;
    d[1] = 2*ha + ex - 2*bo - ap;
    d[2] = 2*sl + ca - 2*nv - sr;
    d[3] = 2*an + ex + 2*nv - 3*sl - ti;
    d[4] = 2*ha + ca - 2*st - ti - 2*ap;
    for (int i = 0; i < 5; i++) begin
      if (d[i] != 0) begin
        v = acc[i] + d[i];
        if (v < 0) v = 0;
        if (v > MAXV) v = MAXV;
        acc[i] = v;
      end else if (acc[i] < BASELINE) begin
        acc[i] = acc[i] + 1;
      end else if (acc[i] > BASELINE) begin
        acc[i] = acc[i] - 1;
      end
    end
  endtask

  // Drive one cycle, advance the model at the edge, then compare just after it.
  task automatic cycle(input bit r, input bit t, input logic [7:0] a,
                       input logic [15:0] s, input logic [7:0] e);
    rst                   = r;
    nt_if.tick            = t;
    nt_if.action          = a;
    nt_if.stimuli         = s;
    nt_if.emotional_state = e;
    @(posedge clk);
    if (r) begin
      model_reset();
      exp_done = 1'b0;
    end else if (t) begin
      model_tick(a, s, e);
      exp_done = 1'b1;
    end else begin
      exp_done = 1'b0;
    end
    #1;
    check_val("level", 32'(nt_if.neurotransmitter_level), 32'(exp_level()));
    check_val("update_done", 32'(nt_if.update_done), 32'(exp_done));
  endtask

  initial begin
    model_reset();
    exp_done = 1'b0;

    cycle(1, 0, 8'h00, 16'h0000, 8'h00);
    cycle(1, 1, 8'h00, 16'h0000, 8'h00);
    check_val("reset_level", 32'(nt_if.neurotransmitter_level), 32'h155);
    check_val("reset_done", 32'(nt_if.update_done), 32'h0);

    // hungry+starving: CORT 22,28,34,40 and SER 14,12,10,8
    for (int i = 0; i < 4; i++) cycle(0, 1, 8'h00, 16'h1800, 8'h00);
    check_val("cort_ser_level", 32'(nt_if.neurotransmitter_level), 32'h056);
    cycle(0, 0, 8'h00, 16'h1800, 8'h00);
    check_val("done_drops", 32'(nt_if.update_done), 32'h0);

    // input changes without tick are ignored
    cycle(0, 0, 8'h01, 16'hFFFF, 8'hFF);
    check_val("no_tick_hold", 32'(nt_if.neurotransmitter_level), 32'h056);

    // decay back to baseline, then hold
    for (int i = 0; i < 28; i++) cycle(0, 1, 8'h00, 16'h0000, 8'h00);
    check_val("decay_hold", 32'(nt_if.neurotransmitter_level), 32'h155);

    // happy: DOP and SER saturate at 63 without wrapping
    for (int i = 0; i < 30; i++) cycle(0, 1, 8'h00, 16'h0000, 8'h01);
    check_val("happy_clamp", 32'(nt_if.neurotransmitter_level), 32'h35D);

    // asleep masks emotions: GABA 32, CORT and NE clamp at 0
    cycle(1, 0, 8'h00, 16'h0000, 8'h00);
    for (int i = 0; i < 8; i++) cycle(0, 1, 8'h01, 16'h0000, 8'hFF);
    check_val("asleep_level", 32'(nt_if.neurotransmitter_level), 32'h124);

    // reset wins over a simultaneous tick
    cycle(1, 0, 8'h00, 16'h0000, 8'h00);
    for (int i = 0; i < 4; i++) cycle(0, 1, 8'h00, 16'h1800, 8'h00);
    cycle(1, 1, 8'h00, 16'h1800, 8'h00);
    check_val("rst_tick_level", 32'(nt_if.neurotransmitter_level), 32'h155);
    check_val("rst_tick_done", 32'(nt_if.update_done), 32'h0);

    for (int i = 0; i < 600; i++) begin
      cycle(($urandom_range(0, 59) == 0),
            ($urandom_range(0, 9) < 7),
            8'($urandom), 16'($urandom), 8'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
